roce_tx_wr_scheduler: RTL and testbench

- Work-request sequencer in front of the RoCE minimal TX stack.
- Accepts RDMA-WRITE work requests (length, remote address, r_key) through a valid/ready port and buffers them in a DEPTH-entry FIFO.
- Issues the requests to the stack one at a time. For each request it drives the stack's parameter inputs and a one-cycle start_transfer pulse, then waits for the stack to finish.
- Owns the queue pair's PSN: advances it by the number of packets each transfer generates.

---
 rtl/roce_tx_wr_scheduler.sv | 174 +++++++++++++++++
 tb/tb_roce_tx_wr_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roce_tx_wr_scheduler.sv
// RDMA-WRITE work-request sequencer: buffers WRs in a small FIFO, issues them one at a
// time to the RoCE TX stack and owns the queue pair's PSN.
module roce_tx_wr_scheduler #(
    parameter int DEPTH       = 4,
    parameter int PMTU_LOG2   = 10,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_wr_valid,
    output logic                       s_wr_ready,
    input  logic [31:0]                s_wr_length,
    input  logic [47:0]                s_wr_rem_addr,
    input  logic [31:0]                s_wr_r_key,
    input  logic [23:0]                cfg_rem_qpn,
    input  logic [31:0]                cfg_rem_ip_addr,
    input  logic [23:0]                cfg_init_psn,
    input  logic                       cfg_psn_load,
    output logic [31:0]                dma_transfer_length,
    output logic [23:0]                rem_qpn,
    output logic [23:0]                rem_psn,
    output logic [31:0]                r_key,
    output logic [47:0]                rem_addr,
    output logic [31:0]                rem_ip_addr,
    output logic                       start_transfer,
    input  logic                       stack_busy,
    output logic [$clog2(DEPTH+1)-1:0] queue_count,
    output logic                       sched_busy,
    output logic                       cpl_valid,
    output logic [23:0]                cpl_next_psn,
    output logic                       err_zero_len,
    output logic                       err_timeout
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int WR_W  = 32 + 48 + 32;
    localparam logic [32:0] PMTU_MASK = 33'((1 << PMTU_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WR_W-1:0]  wr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [23:0]      psn_q, psn_d;

    logic [31:0] len_q;
    logic [47:0] addr_q;
    logic [31:0] rkey_q;
    logic [23:0] qpn_q;
    logic [23:0] rem_psn_q;
    logic [31:0] ip_q;
    logic        err_zero_len_q;

    logic        push_fire, push_store, pop;
    logic        start_d, cpl_d, err_to_d;
    logic [23:0] npkt, psn_after;

    assign s_wr_ready = count_q < CNT_W'(DEPTH);
    assign push_fire  = s_wr_valid && s_wr_ready;
    assign push_store = push_fire && (s_wr_length != 32'd0);
    assign count_d    = count_q + CNT_W'(push_store) - CNT_W'(pop);

    // 33-bit sum so a 0xFFFFFFFF-byte transfer still rounds up correctly
    assign npkt      = 24'(({1'b0, len_q} + PMTU_MASK) >> PMTU_LOG2);
    assign psn_after = psn_q + npkt;

    always_ff @(posedge clk) begin
        if (push_store) begin
            wr_mem[wr_ptr_q] <= {s_wr_length, s_wr_rem_addr, s_wr_r_key};
        end
    end

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        psn_d    = psn_q;
        pop      = 1'b0;
        start_d  = 1'b0;
        cpl_d    = 1'b0;
        err_to_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_psn_load) begin
                    psn_d = cfg_init_psn;
                end else if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                start_d  = 1'b1;
                to_cnt_d = '0;
                state_d  = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (stack_busy) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!stack_busy) begin
                    cpl_d   = 1'b1;
                    psn_d   = psn_after;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            to_cnt_q       <= '0;
            psn_q          <= '0;
            len_q          <= '0;
            addr_q         <= '0;
            rkey_q         <= '0;
            qpn_q          <= '0;
            rem_psn_q      <= '0;
            ip_q           <= '0;
            err_zero_len_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            to_cnt_q       <= to_cnt_d;
            psn_q          <= psn_d;
            err_zero_len_q <= push_fire && (s_wr_length == 32'd0);
            if (push_store) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            // Stack parameters are captured at pop and held until the next pop
            if (pop) begin
                rd_ptr_q                 <= rd_ptr_q + PTR_W'(1);
                {len_q, addr_q, rkey_q}  <= wr_mem[rd_ptr_q];
                qpn_q                    <= cfg_rem_qpn;
                ip_q                     <= cfg_rem_ip_addr;
                rem_psn_q                <= psn_q;
            end
        end
    end

    assign dma_transfer_length = len_q;
    assign rem_addr            = addr_q;
    assign r_key               = rkey_q;
    assign rem_qpn             = qpn_q;
    assign rem_ip_addr         = ip_q;
    assign rem_psn             = rem_psn_q;
    assign start_transfer      = start_d;
    assign queue_count         = count_q;
    assign sched_busy          = (state_q != IDLE);
    assign cpl_valid           = cpl_d;
    assign cpl_next_psn        = cpl_d ? psn_after : 24'd0;
    assign err_zero_len        = err_zero_len_q;
    assign err_timeout         = err_to_d;

endmodule

// File: tb/tb_roce_tx_wr_scheduler.sv
// Randomized self-checking bench for roce_tx_wr_scheduler with a behavioural stack model
// and a PSN reference model based on ceil(length / PMTU).
module tb_roce_tx_wr_scheduler;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_wr_valid = 1'b0;
    logic        s_wr_ready;
    logic [31:0] s_wr_length = '0;
    logic [47:0] s_wr_rem_addr = '0;
    logic [31:0] s_wr_r_key = '0;
    logic [23:0] cfg_rem_qpn = '0;
    logic [31:0] cfg_rem_ip_addr = '0;
    logic [23:0] cfg_init_psn = '0;
    logic        cfg_psn_load = 1'b0;
    logic [31:0] dma_transfer_length;
    logic [23:0] rem_qpn, rem_psn;
    logic [31:0] r_key;
    logic [47:0] rem_addr;
    logic [31:0] rem_ip_addr;
    logic        start_transfer;
    logic        stack_busy = 1'b0;
    logic [2:0]  queue_count;
    logic        sched_busy, cpl_valid;
    logic [23:0] cpl_next_psn;
    logic        err_zero_len, err_timeout;

    roce_tx_wr_scheduler #(.DEPTH(DEPTH), .PMTU_LOG2(10), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready),
        .s_wr_length(s_wr_length), .s_wr_rem_addr(s_wr_rem_addr), .s_wr_r_key(s_wr_r_key),
        .cfg_rem_qpn(cfg_rem_qpn), .cfg_rem_ip_addr(cfg_rem_ip_addr),
        .cfg_init_psn(cfg_init_psn), .cfg_psn_load(cfg_psn_load),
        .dma_transfer_length(dma_transfer_length), .rem_qpn(rem_qpn), .rem_psn(rem_psn),
        .r_key(r_key), .rem_addr(rem_addr), .rem_ip_addr(rem_ip_addr),
        .start_transfer(start_transfer), .stack_busy(stack_busy),
        .queue_count(queue_count), .sched_busy(sched_busy),
        .cpl_valid(cpl_valid), .cpl_next_psn(cpl_next_psn),
        .err_zero_len(err_zero_len), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] len;
        logic [47:0] addr;
        logic [31:0] rkey;
        logic [23:0] qpn;
        logic [31:0] ip;
        logic [23:0] psn;
        int          cyc;
    } start_t;

    typedef struct {
        logic [31:0] len;
        logic [47:0] addr;
        logic [31:0] rkey;
    } wr_t;

    start_t      st_q[$];
    logic [23:0] cpl_q[$];
    int          cpl_cyc_q[$];
    wr_t         exp_q[$];
    logic [23:0] model_psn = '0;
    int zl_cnt = 0, zl_cyc = 0, to_cnt = 0, to_cyc = 0;

    // Observation of DUT events, one line per transaction
    always @(negedge clk) begin
        if (!rst) begin
            if (start_transfer) begin
                st_q.push_back('{dma_transfer_length, rem_addr, r_key, rem_qpn, rem_ip_addr, rem_psn, cyc});
                $display("start   cyc=%0d psn=%06h len=%0d", cyc, rem_psn, dma_transfer_length);
            end
            if (cpl_valid) begin
                cpl_q.push_back(cpl_next_psn);
                cpl_cyc_q.push_back(cyc);
                $display("cpl     cyc=%0d next_psn=%06h", cyc, cpl_next_psn);
            end
            if (err_zero_len) begin
                zl_cnt++;
                zl_cyc = cyc;
                $display("zerolen cyc=%0d", cyc);
            end
            if (err_timeout) begin
                to_cnt++;
                to_cyc = cyc;
                $display("timeout cyc=%0d", cyc);
            end
        end
    end

    // Stack model: busy from 2 cycles after start for 10 cycles, held while stalled,
    // or never asserted for the next ignore_n starts.
    int sc = 0;
    int ignore_n = 0;
    bit stall = 1'b0;
    bit start_seen = 1'b0, rst_seen = 1'b1;
    always @(negedge clk) begin
        start_seen = start_transfer;
        rst_seen   = rst;
    end
    always @(posedge clk) begin
        #1;
        if (rst_seen) sc = 0;
        else if (start_seen) begin
            if (ignore_n > 0) begin
                ignore_n--;
                sc = 0;
            end else sc = 1;
        end else if (sc != 0 && sc < 1000000) sc++;
        stack_busy = (sc >= 2) && (stall || sc < 12);
    end

    function automatic logic [23:0] npkt_of(input logic [31:0] len);
        longint unsigned l;
        l = len;
        l = (l + 1023) / 1024;
        return l[23:0];
    endfunction

    task automatic clear_obs();
        st_q.delete();
        cpl_q.delete();
        cpl_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic load_psn(input logic [23:0] v);
        cfg_init_psn = v;
        cfg_psn_load = 1'b1;
        @(posedge clk); #1;
        cfg_psn_load = 1'b0;
        model_psn = v;
    endtask

    task automatic push_wr(input logic [31:0] len, input logic [47:0] addr,
                           input logic [31:0] rkey, output int acc);
        bit ok;
        int n;
        s_wr_valid = 1'b1; s_wr_length = len; s_wr_rem_addr = addr; s_wr_r_key = rkey;
        ok = 1'b0; n = 0; acc = -1;
        while (!ok && n < 400) begin
            @(negedge clk);
            ok  = s_wr_ready;
            acc = cyc;
            @(posedge clk); #1;
            n++;
        end
        s_wr_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_handshake: ready=0 for %0d cycles, required 1", n);
        end else if (len != 0) exp_q.push_back('{len, addr, rkey});
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        int n;
        done = 1'b0; n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            done = !sched_busy && queue_count == 0 && !stack_busy;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d required 0", queue_count); end
        checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", sched_busy); end
        checks++; if (start_transfer !== 1'b0) begin errors++; $display("FAIL rst_start: got %b required 0", start_transfer); end
        checks++; if ({rem_psn, dma_transfer_length, rem_addr, r_key} !== '0) begin errors++; $display("FAIL rst_stack_outs: got psn=%h len=%h required 0", rem_psn, dma_transfer_length); end
        checks++; if ({cpl_valid, err_zero_len, err_timeout} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b required 000", {cpl_valid, err_zero_len, err_timeout}); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (s_wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", s_wr_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_wr();
        int acc;
        clear_obs();
        cfg_rem_qpn = 24'h16;
        cfg_rem_ip_addr = 32'h0BD40116;
        load_psn(24'd302);
        push_wr(32'd128, 48'd0, 32'hDEFE, acc);
        wait_idle(100);
        checks++; if (st_q.size() != 1) begin errors++; $display("FAIL single_nstart: got %0d required 1", st_q.size()); end
        if (st_q.size() >= 1) begin
            checks++; if (st_q[0].psn !== 24'd302) begin errors++; $display("FAIL single_psn: got %0d required 302", st_q[0].psn); end
            checks++; if (st_q[0].len !== 32'd128 || st_q[0].rkey !== 32'hDEFE || st_q[0].addr !== 48'd0) begin errors++; $display("FAIL single_params: got len=%0d rkey=%h addr=%h required 128/DEFE/0", st_q[0].len, st_q[0].rkey, st_q[0].addr); end
            checks++; if (st_q[0].qpn !== 24'h16 || st_q[0].ip !== 32'h0BD40116) begin errors++; $display("FAIL single_dest: got qpn=%h ip=%h required 16/0BD40116", st_q[0].qpn, st_q[0].ip); end
            checks++; if (st_q[0].cyc - acc != 2) begin errors++; $display("FAIL single_latency: got %0d required 2", st_q[0].cyc - acc); end
        end
        checks++; if (cpl_q.size() != 1) begin errors++; $display("FAIL single_ncpl: got %0d required 1", cpl_q.size()); end
        if (cpl_q.size() >= 1 && st_q.size() >= 1) begin
            checks++; if (cpl_q[0] !== 24'd303) begin errors++; $display("FAIL single_cpl_psn: got %0d required 303", cpl_q[0]); end
            checks++; if (cpl_cyc_q[0] - st_q[0].cyc != 12) begin errors++; $display("FAIL single_cpl_time: got %0d required 12", cpl_cyc_q[0] - st_q[0].cyc); end
        end
        model_psn = 24'd303;
    endtask

    task automatic test_rounding();
        int acc;
        logic [23:0] mp;
        logic [31:0] lens [3];
        lens[0] = 32'd1024; lens[1] = 32'd1025; lens[2] = 32'd4096;
        clear_obs();
        load_psn(24'd0);
        for (int i = 0; i < 3; i++) push_wr(lens[i], 48'(i * 4096), 32'h100 + 32'(i), acc);
        wait_idle(200);
        checks++; if (st_q.size() != 3 || cpl_q.size() != 3) begin errors++; $display("FAIL round_counts: got starts=%0d cpls=%0d required 3/3", st_q.size(), cpl_q.size()); end
        mp = model_psn;
        for (int i = 0; i < 3 && i < st_q.size() && i < cpl_q.size(); i++) begin
            checks++; if (st_q[i].psn !== mp || st_q[i].len !== exp_q[i].len) begin errors++; $display("FAIL round_start%0d: got psn=%0d len=%0d required psn=%0d len=%0d", i, st_q[i].psn, st_q[i].len, mp, exp_q[i].len); end
            mp = mp + npkt_of(exp_q[i].len);
            checks++; if (cpl_q[i] !== mp) begin errors++; $display("FAIL round_cpl%0d: got %0d required %0d", i, cpl_q[i], mp); end
            if (i > 0) begin
                checks++; if (st_q[i].cyc - cpl_cyc_q[i-1] != 2) begin errors++; $display("FAIL round_b2b%0d: got %0d required 2", i, st_q[i].cyc - cpl_cyc_q[i-1]); end
            end
        end
        if (cpl_q.size() == 3) begin
            checks++; if (cpl_q[2] !== 24'd7) begin errors++; $display("FAIL round_final: got %0d required 7", cpl_q[2]); end
        end
        model_psn = mp;
    endtask

    task automatic test_psn_wrap();
        int acc;
        clear_obs();
        load_psn(24'hFFFFFE);
        push_wr(32'd4096, 48'h1234_5678_9ABC, 32'h55, acc);
        wait_idle(100);
        checks++; if (cpl_q.size() != 1 || cpl_q[0] !== 24'h000002) begin errors++; $display("FAIL wrap_cpl: got n=%0d psn=%h required 1/000002", cpl_q.size(), cpl_q.size() ? cpl_q[0] : 24'h0); end
        model_psn = 24'h000002;
    endtask

    task automatic test_random();
        int acc;
        logic [23:0] mp;
        logic [31:0] len;
        clear_obs();
        load_psn(24'($urandom()));
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0: len = $urandom_range(1, 1024);
                1: len = $urandom_range(1025, 9000);
                2: len = 32'hFFFFFFFF;
                default: len = $urandom();
            endcase
            push_wr(len, {16'($urandom()), $urandom()}, $urandom(), acc);
        end
        wait_idle(400);
        checks++; if (st_q.size() != exp_q.size() || cpl_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_counts: got starts=%0d cpls=%0d required %0d", st_q.size(), cpl_q.size(), exp_q.size()); end
        mp = model_psn;
        for (int i = 0; i < exp_q.size() && i < st_q.size() && i < cpl_q.size(); i++) begin
            checks++; if (st_q[i].psn !== mp || st_q[i].len !== exp_q[i].len || st_q[i].addr !== exp_q[i].addr || st_q[i].rkey !== exp_q[i].rkey) begin errors++; $display("FAIL rand_start%0d: got psn=%h len=%h required psn=%h len=%h", i, st_q[i].psn, st_q[i].len, mp, exp_q[i].len); end
            mp = mp + npkt_of(exp_q[i].len);
            checks++; if (cpl_q[i] !== mp) begin errors++; $display("FAIL rand_cpl%0d: got %h required %h", i, cpl_q[i], mp); end
        end
        model_psn = mp;
    endtask

    task automatic test_backpressure();
        int acc;
        logic [23:0] mp;
        clear_obs();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) push_wr(32'd512 * 32'(i + 1), 48'(i), 32'hA0 + 32'(i), acc);
        s_wr_valid = 1'b1; s_wr_length = 32'd6000; s_wr_rem_addr = 48'd5; s_wr_r_key = 32'hA5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (queue_count !== 3'd4 || s_wr_ready !== 1'b0) begin errors++; $display("FAIL bp_full%0d: got count=%0d ready=%b required 4/0", i, queue_count, s_wr_ready); end
        end
        checks++; if (st_q.size() != 1) begin errors++; $display("FAIL bp_popped: got %0d required 1", st_q.size()); end
        @(posedge clk); #1;
        stall = 1'b0;
        push_wr(32'd6000, 48'd5, 32'hA5, acc);
        wait_idle(400);
        checks++; if (st_q.size() != 6 || cpl_q.size() != 6) begin errors++; $display("FAIL bp_counts: got starts=%0d cpls=%0d required 6/6", st_q.size(), cpl_q.size()); end
        mp = model_psn;
        for (int i = 0; i < exp_q.size() && i < st_q.size() && i < cpl_q.size(); i++) begin
            checks++; if (st_q[i].psn !== mp || st_q[i].rkey !== exp_q[i].rkey || st_q[i].len !== exp_q[i].len) begin errors++; $display("FAIL bp_order%0d: got psn=%h rkey=%h required psn=%h rkey=%h", i, st_q[i].psn, st_q[i].rkey, mp, exp_q[i].rkey); end
            mp = mp + npkt_of(exp_q[i].len);
            checks++; if (cpl_q[i] !== mp) begin errors++; $display("FAIL bp_cpl%0d: got %h required %h", i, cpl_q[i], mp); end
        end
        model_psn = mp;
    endtask

    task automatic test_errors();
        int acc, zl0, to0;
        clear_obs();
        zl0 = zl_cnt;
        push_wr(32'd0, 48'hDEAD, 32'h1, acc);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (zl_cnt != zl0 + 1) begin errors++; $display("FAIL zl_pulses: got %0d required %0d", zl_cnt - zl0, 1); end
        checks++; if (zl_cyc != acc + 1) begin errors++; $display("FAIL zl_timing: got cyc %0d required %0d", zl_cyc, acc + 1); end
        checks++; if (st_q.size() != 0 || queue_count !== 3'd0) begin errors++; $display("FAIL zl_dropped: got starts=%0d count=%0d required 0/0", st_q.size(), queue_count); end

        clear_obs();
        to0 = to_cnt;
        load_psn(24'd50);
        ignore_n = 1;
        push_wr(32'd3000, 48'h10, 32'hB1, acc);
        push_wr(32'd100, 48'h20, 32'hB2, acc);
        wait_idle(300);
        checks++; if (to_cnt != to0 + 1) begin errors++; $display("FAIL to_pulses: got %0d required 1", to_cnt - to0); end
        checks++; if (st_q.size() != 2 || cpl_q.size() != 1) begin errors++; $display("FAIL to_counts: got starts=%0d cpls=%0d required 2/1", st_q.size(), cpl_q.size()); end
        if (st_q.size() == 2 && cpl_q.size() == 1) begin
            checks++; if (to_cyc - st_q[0].cyc != 16) begin errors++; $display("FAIL to_timing: got %0d required 16", to_cyc - st_q[0].cyc); end
            checks++; if (st_q[0].psn !== 24'd50 || st_q[1].psn !== 24'd50) begin errors++; $display("FAIL to_psn_kept: got %0d,%0d required 50,50", st_q[0].psn, st_q[1].psn); end
            checks++; if (st_q[1].len !== 32'd100 || st_q[1].cyc - to_cyc != 2) begin errors++; $display("FAIL to_next: got len=%0d gap=%0d required 100/2", st_q[1].len, st_q[1].cyc - to_cyc); end
            checks++; if (cpl_q[0] !== 24'd51) begin errors++; $display("FAIL to_cpl: got %0d required 51", cpl_q[0]); end
        end
        model_psn = 24'd51;
    endtask

    task automatic test_reset_mid();
        int acc, c0;
        clear_obs();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) push_wr(32'd700, 48'(i), 32'hC0 + 32'(i), acc);
        repeat (6) @(posedge clk);
        #1;
        checks++; if (queue_count !== 3'd2 || sched_busy !== 1'b1) begin errors++; $display("FAIL rm_pre: got count=%0d busy=%b required 2/1", queue_count, sched_busy); end
        c0 = cpl_q.size();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        checks++; if (queue_count !== 3'd0 || sched_busy !== 1'b0 || start_transfer !== 1'b0) begin errors++; $display("FAIL rm_state: got count=%0d busy=%b start=%b required 0/0/0", queue_count, sched_busy, start_transfer); end
        checks++; if ({rem_psn, dma_transfer_length, rem_addr, r_key, rem_qpn, rem_ip_addr} !== '0) begin errors++; $display("FAIL rm_outs: got psn=%h len=%h required 0", rem_psn, dma_transfer_length); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (cpl_q.size() != c0 || st_q.size() != 1) begin errors++; $display("FAIL rm_no_cpl: got cpls=%0d starts=%0d required %0d/1", cpl_q.size(), st_q.size(), c0); end
        clear_obs();
        model_psn = 24'd0;
        push_wr(32'd2048, 48'h99, 32'hD0, acc);
        wait_idle(100);
        checks++; if (st_q.size() != 1 || cpl_q.size() != 1 || st_q[0].psn !== 24'd0 || cpl_q[0] !== 24'd2) begin errors++; $display("FAIL rm_psn_zero: got starts=%0d cpls=%0d required psn 0 then cpl 2", st_q.size(), cpl_q.size()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_wr();
        test_rounding();
        test_psn_wrap();
        test_random();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
